mul_issue_ctrl: RTL and testbench
=================================

MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high: ports mul_clk and reset.
REQ-002 SHALL have ports, one per line:
- mul_clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_op  in  2  00 mul.w (low word), 01 mulh.w (signed high), 10 mulh.wu (unsigned high), 11 same as 00
- in_src1  in  32  multiplicand
- in_src2  in  32  multiplier
- in_dest  in  5  destination register tag
- flush  in  1  discard all in-flight and buffered ops
- m_signed  out  1  signed mode to multiplier
- m_x  out  32  operand x to multiplier
- m_y  out  32  operand y to multiplier
- m_result  in  64  multiplier product
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_result  out  32  selected product word
- out_dest  out  5  tag of out_result
- perf_issue_cnt  out  32  accepted-op counter (present only with MUL_CTRL_PERF_EN)

Function
REQ-003 Multiplier contract: operands driven in cycle T yield m_result in cycle T+1; the multiplier pipeline register is free-running and never stalls.
REQ-004 m_x = in_src1, m_y = in_src2, combinationally every cycle; m_signed = (in_op == 01).
REQ-005 Accept in cycle T: stage-2 tag register loads s2_valid=1, s2_op=in_op, s2_dest=in_dest at end of T; no accept loads s2_valid=0.
REQ-006 Word select: op 00/11 -> m_result[31:0]; op 01/10 -> m_result[63:32].
REQ-007 Result queue: 2-entry FIFO of {result, dest}; occupancy cnt in 0..2; wraps read/write pointers modulo 2.
REQ-008 Output: if cnt>0, out_* from queue head; else if s2_valid, out_* bypass from stage 2 (selected m_result, s2_dest); else out_valid=0.
REQ-009 Stage-2 entry enqueues at end of cycle unless it was presented via bypass and out_ready=1.
REQ-010 Queue pops at end of cycle when cnt>0 && out_ready; simultaneous pop and enqueue keeps cnt unchanged and preserves order.
REQ-011 in_ready = !flush && (cnt + s2_valid < 2); never depends on in_valid or out_ready.
REQ-012 Latency 1 cycle accept-to-out_valid when queue empty; sustains one op per cycle with out_ready held 1.
REQ-013 out_valid, once asserted without flush, holds with stable out_result/out_dest until out_ready.
REQ-014 flush in cycle T: out_valid=0 and in_ready=0 in T; end of T: cnt=0, pointers=0, s2_valid=0; no result from ops accepted at or before T is ever output.
REQ-015 Simultaneous flush and in_valid: request not accepted.

Reset
REQ-016 Reset at end of cycle sets cnt=0, pointers=0, s2_valid=0, perf_issue_cnt=0; in the reset cycle out_valid=0 and in_ready=0.
REQ-017 Reset mid-operation discards all in-flight ops identically to flush; first accept possible in cycle after reset deasserts.

Configuration
REQ-018 Macro MUL_CTRL_PERF_EN: defined -> perf_issue_cnt increments by 1 per accept, wraps 0xFFFFFFFF->0, not cleared by flush; undefined -> port and counter absent, all other behaviour identical.

Verification
REQ-019 op 00, src1=0xFFFFFFFF, src2=0x00000002, out_ready=1 -> next cycle out_valid=1, out_result=0xFFFFFFFE.
REQ-020 op 01 src1=0xFFFFFFFF, src2=0x00000002 -> 0xFFFFFFFF; op 10 same operands -> 0x00000001.
REQ-021 out_ready=0, three back-to-back requests -> two accepted, in_ready=0 third cycle; release -> results in order, tags preserved.
REQ-022 10 consecutive accepts with out_ready=1 -> 10 results in consecutive cycles, in_ready never drops.
REQ-023 Queue holding 2 entries plus flush -> out_valid=0 next cycles, no stale result after new accept.
REQ-024 With MUL_CTRL_PERF_EN, 5 accepts then reset -> perf_issue_cnt 5 then 0.

Source files
------------

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: issue/writeback controller wrapped around a one-cycle,
// free-running multiplier. A request is accepted in cycle T and its product
// shows up on m_result in T+1. The product is then either passed straight
// through to the consumer or parked in a 2-entry result queue. Flush and
// reset discard every op that is in flight or buffered.
// Optional feature: define MUL_CTRL_PERF_EN to add the perf_issue_cnt port,
// which counts accepted ops.
module mul_issue_ctrl (
  input  logic        mul_clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_src1,
  input  logic [31:0] in_src2,
  input  logic [4:0]  in_dest,
  input  logic        flush,
  output logic        m_signed,
  output logic [31:0] m_x,
  output logic [31:0] m_y,
  input  logic [63:0] m_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_dest
`ifdef MUL_CTRL_PERF_EN
  ,
  output logic [31:0] perf_issue_cnt
`endif
);

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  dest;
  } entry_t;

  // Stage-2 tag register: describes the product arriving on m_result this cycle.
  logic        s2_valid_q, s2_valid_d;
  logic [1:0]  s2_op_q, s2_op_d;
  logic [4:0]  s2_dest_q, s2_dest_d;

  // Result queue state.
  entry_t      fifo_q [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  cnt_q, cnt_d;

  logic        accept;
  logic        bypass;
  logic        enq;
  logic        pop;
  logic [1:0]  outstanding;
  logic [31:0] s2_word;

  // Operands reach the multiplier straight from the request port.
  assign m_x      = in_src1;
  assign m_y      = in_src2;
  assign m_signed = (in_op == 2'b01);

  // Ops 01 and 10 want the high word, ops 00 and 11 want the low word.
  assign s2_word = (s2_op_q[1] ^ s2_op_q[0]) ? m_result[63:32] : m_result[31:0];

  // The stage-2 op plus the queued entries can never exceed the queue depth.
  assign outstanding = cnt_q + {1'b0, s2_valid_q};
  assign in_ready    = !reset && !flush && (outstanding < 2'd2);
  assign accept      = in_valid && in_ready;

  // When the queue is empty, the stage-2 product is presented directly.
  assign bypass = (cnt_q == 2'd0) && s2_valid_q;
  assign enq    = s2_valid_q && !(bypass && out_ready);
  assign pop    = (cnt_q != 2'd0) && out_ready;

  // Output selection: the queue head takes priority over the stage-2 bypass.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    out_valid  = 1'b0;
    out_result = s2_word;
    out_dest   = s2_dest_q;
    if (!reset && !flush) begin
      if (cnt_q != 2'd0) begin
        out_valid  = 1'b1;
        out_result = fifo_q[rd_ptr_q].result;
        out_dest   = fifo_q[rd_ptr_q].dest;
      end else if (s2_valid_q) begin
        out_valid = 1'b1;
      end
    end
  end

  // Next state for the stage-2 tag and the queue bookkeeping; flush wipes both.
  always_comb begin
    s2_valid_d = accept;
    s2_op_d    = in_op;
    s2_dest_d  = in_dest;
    wr_ptr_d   = wr_ptr_q ^ enq;
    rd_ptr_d   = rd_ptr_q ^ pop;
    cnt_d      = cnt_q;
    unique case ({enq, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    if (flush) begin
      s2_valid_d = 1'b0;
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
      cnt_d      = 2'd0;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge mul_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_op_q    <= 2'b00;
      s2_dest_q  <= 5'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      s2_valid_q <= s2_valid_d;
      s2_op_q    <= s2_op_d;
      s2_dest_q  <= s2_dest_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Capture the selected product into the queue slot at the write pointer.
  always_ff @(posedge mul_clk) begin
    // NOTE: queue storage is not reset; cnt_q alone decides which slots hold live data.
    if (enq && !flush && !reset) begin
      fifo_q[wr_ptr_q] <= '{result: s2_word, dest: s2_dest_q};
    end
  end

`ifdef MUL_CTRL_PERF_EN
  logic [31:0] perf_cnt_q;

  // Count accepted ops; flush leaves the count alone and it wraps naturally.
  always_ff @(posedge mul_clk) begin
    if (reset) begin
      perf_cnt_q <= 32'd0;
    end else if (accept) begin
      perf_cnt_q <= perf_cnt_q + 32'd1;
    end
  end

  assign perf_issue_cnt = perf_cnt_q;
`endif

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl: self-checking bench for mul_issue_ctrl. It models the
// one-cycle multiplier, keeps a queue-based reference of the ops that have
// been accepted but not yet delivered, and checks the DUT every cycle.
module tb_mul_issue_ctrl;

  logic        mul_clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic [4:0]  in_dest;
  logic        flush;
  logic        m_signed;
  logic [31:0] m_x;
  logic [31:0] m_y;
  logic [63:0] m_result = 64'd0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_dest;
`ifdef MUL_CTRL_PERF_EN
  logic [31:0] perf_issue_cnt;
`endif

  mul_issue_ctrl dut (
    .mul_clk    (mul_clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .in_dest    (in_dest),
    .flush      (flush),
    .m_signed   (m_signed),
    .m_x        (m_x),
    .m_y        (m_y),
    .m_result   (m_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_dest   (out_dest)
`ifdef MUL_CTRL_PERF_EN
    ,
    .perf_issue_cnt (perf_issue_cnt)
`endif
  );

  always #5 mul_clk = ~mul_clk;

  // One-cycle multiplier: the full 64-bit product appears one cycle after the operands.
  always @(posedge mul_clk) begin
    if (m_signed)
      m_result <= {{32{m_x[31]}}, m_x} * {{32{m_y[31]}}, m_y};
    else
      m_result <= {32'd0, m_x} * {32'd0, m_y};
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference result straight from the op definitions.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    sp = longint'(signed'(a)) * longint'(signed'(b));
    up = longint'(a) * longint'(b);
    case (op)
      2'b01:   return sp[63:32];
      2'b10:   return up[63:32];
      default: return up[31:0];
    endcase
  endfunction

  // Reference model: ops accepted in earlier cycles and not yet handed to the consumer.
  typedef struct {
    logic [31:0] r;
    logic [4:0]  d;
  } exp_t;
  exp_t        mq[$];
  int unsigned perf_m = 0;

  // Values sampled in the most recent cycle, for the hand-written sequences.
  logic        s_valid, s_ready;
  logic [31:0] s_result;
  logic [4:0]  s_dest;

  // Sample at the falling edge, check against the model, then advance the model
  // with what the coming rising edge will do. Returns just after that rising edge.
  task automatic cycle();
    logic exp_ready, exp_valid;
    exp_t e;
    @(negedge mul_clk);
    s_valid  = out_valid;
    s_ready  = in_ready;
    s_result = out_result;
    s_dest   = out_dest;
    exp_ready = !reset && !flush && (mq.size() < 2);
    exp_valid = !reset && !flush && (mq.size() > 0);
    check("in_ready", in_ready, exp_ready);
    check("out_valid", out_valid, exp_valid);
    check("m_x", m_x, in_src1);
    check("m_y", m_y, in_src2);
    check("m_signed", m_signed, in_op == 2'b01);
    if (exp_valid && out_valid) begin
      check("out_result", out_result, mq[0].r);
      check("out_dest", out_dest, mq[0].d);
    end
`ifdef MUL_CTRL_PERF_EN
    check("perf_issue_cnt", perf_issue_cnt, perf_m);
`endif
    if (reset || flush) begin
      mq.delete();
      if (reset) perf_m = 0;
    end else begin
      if (exp_valid && out_ready) void'(mq.pop_front());
      if (in_valid && exp_ready) begin
        e.r = ref_mul(in_op, in_src1, in_src2);
        e.d = in_dest;
        mq.push_back(e);
        perf_m++;
      end
    end
    @(posedge mul_clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[8];

  int n_out;
  int drops;

  initial begin
    vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE};
    vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
    vecs[2] = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
    vecs[3] = '{2'b11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000};
    vecs[4] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[5] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[6] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[7] = '{2'b00, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780};

    reset = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_src1 = '0; in_src2 = '0;
    in_dest = '0; flush = 1'b0; out_ready = 1'b1;

    // Reset state.
    cycle();
    cycle();
    check("rst_out_valid", s_valid, 1'b0);
    check("rst_in_ready", s_ready, 1'b0);
    reset = 1'b0;

    // Single ops, one at a time, with the consumer always ready.
    foreach (vecs[i]) begin
      in_valid = 1'b1; in_op = vecs[i].op; in_src1 = vecs[i].a; in_src2 = vecs[i].b;
      in_dest = 5'(i + 1); out_ready = 1'b1;
      cycle();
      check("tbl_accept", s_ready, 1'b1);
      in_valid = 1'b0;
      cycle();
      check("tbl_valid", s_valid, 1'b1);
      check("tbl_result", s_result, vecs[i].exp);
      check("tbl_dest", s_dest, 5'(i + 1));
    end

    // Stalled consumer: two of three back-to-back requests are accepted.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_op = 2'b00; in_src1 = 32'(k + 2); in_src2 = 32'd3;
      in_dest = 5'(20 + k);
      cycle();
      check("bp_ready", s_ready, k < 2);
    end
    in_valid = 1'b0;
    cycle();
    check("bp_hold_valid", s_valid, 1'b1);
    check("bp_hold_result", s_result, 32'd6);
    out_ready = 1'b1;
    cycle();
    check("bp_first_result", s_result, 32'd6);
    check("bp_first_dest", s_dest, 5'd20);
    cycle();
    check("bp_second_result", s_result, 32'd9);
    check("bp_second_dest", s_dest, 5'd21);
    cycle();
    check("bp_drained", s_valid, 1'b0);

    // Ten back-to-back accepts with the consumer always ready.
    n_out = 0; drops = 0; out_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      in_valid = (k < 10); in_op = 2'(k); in_src1 = $urandom; in_src2 = $urandom;
      in_dest = 5'(k);
      cycle();
      if (s_valid) n_out++;
      if (k < 10 && !s_ready) drops++;
    end
    in_valid = 1'b0;
    check("stream_out_count", n_out, 10);
    check("stream_ready_drops", drops, 0);

    // Full queue plus flush (with a simultaneous request), then a fresh op.
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_op = 2'b00; in_src1 = 32'(100 + k); in_src2 = 32'd1;
      in_dest = 5'(k + 1);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    check("fl_full_valid", s_valid, 1'b1);
    flush = 1'b1; in_valid = 1'b1; in_src1 = 32'd55;
    cycle();
    check("fl_valid", s_valid, 1'b0);
    check("fl_ready", s_ready, 1'b0);
    flush = 1'b0; in_valid = 1'b0;
    cycle();
    check("fl_after_valid", s_valid, 1'b0);
    in_valid = 1'b1; in_op = 2'b00; in_src1 = 32'd3; in_src2 = 32'd5; in_dest = 5'd7;
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    check("fl_new_result", s_result, 32'd15);
    check("fl_new_dest", s_dest, 5'd7);
    cycle();
    check("fl_no_stale", s_valid, 1'b0);

`ifdef MUL_CTRL_PERF_EN
    // Performance counter: five accepts, then reset clears it.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_src1 = $urandom;
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    check("perf_five", perf_issue_cnt, 32'd5);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    check("perf_cleared", perf_issue_cnt, 32'd0);
`endif

    // Randomized traffic, including occasional flush and reset.
    for (int k = 0; k < 3000; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      reset     = ($urandom_range(0, 199) == 0);
      in_op     = 2'($urandom_range(0, 3));
      in_src1   = $urandom;
      in_src2   = $urandom;
      in_dest   = 5'($urandom_range(0, 31));
      cycle();
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
